// File: rtl/or_gate_demux.sv
// or_gate_demux: combinational a|b plus a registered one-hot lane demux of the result.
// Define OR_GATE_DEMUX_HITCNT_EN to add a saturating hit_cnt of nonzero in-range captures.
module or_gate_demux #(
  parameter int WIDTH   = 1,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [SEL_W-1:0]         sel,
  output logic [WIDTH-1:0]         or_o,
  output logic [NUM_OUT*WIDTH-1:0] demux_o,
  output logic [NUM_OUT-1:0]       demux_vld,
`ifdef OR_GATE_DEMUX_HITCNT_EN
  output logic [15:0]              hit_cnt,
`endif
  output logic                     sel_err
);
  logic [NUM_OUT*WIDTH-1:0] demux_q, demux_d;
  logic [NUM_OUT-1:0]       vld_q, vld_d;
  logic                     err_q, err_d;
  logic                     in_rng;
  assign or_o   = a | b;
  assign in_rng = 32'(sel) < NUM_OUT;
  // A capture clears every lane except the selected one; idle and out-of-range cycles hold data.
  always_comb begin
    demux_d = demux_q;
    vld_d   = '0;
    err_d   = en ? !in_rng : err_q;
    if (en && in_rng) begin
      demux_d = '0;
      demux_d[sel*WIDTH +: WIDTH] = or_o;
      vld_d[sel] = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      demux_q <= '0;
      vld_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      demux_q <= demux_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end
  assign demux_o   = demux_q;
  assign demux_vld = vld_q;
  assign sel_err   = err_q;
`ifdef OR_GATE_DEMUX_HITCNT_EN
  logic [15:0] hit_q, hit_d;
  assign hit_d = (en && in_rng && |or_o && hit_q != 16'hFFFF) ? hit_q + 16'd1 : hit_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_q <= '0;
    else     hit_q <= hit_d;
  end
  assign hit_cnt = hit_q;
`endif
endmodule

// File: tb/tb_or_gate_demux.sv
// tb_or_gate_demux: directed self-checking bench for or_gate_demux (NUM_OUT=4 and NUM_OUT=3).
module tb_or_gate_demux;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       a   = 1'b0;
  logic       b   = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       or4, or3;
  logic [3:0] dm4, vld4;
  logic [2:0] dm3, vld3;
  logic       err4, err3;
  int         n_chk = 0;
  int         n_fail = 0;
`ifdef OR_GATE_DEMUX_HITCNT_EN
  logic [15:0] hc4, hc3;
`endif

  always #5 clk = ~clk;

  or_gate_demux #(.WIDTH(1), .NUM_OUT(4)) u4 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .sel(sel),
    .or_o(or4), .demux_o(dm4), .demux_vld(vld4),
`ifdef OR_GATE_DEMUX_HITCNT_EN
    .hit_cnt(hc4),
`endif
    .sel_err(err4));

  or_gate_demux #(.WIDTH(1), .NUM_OUT(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .sel(sel),
    .or_o(or3), .demux_o(dm3), .demux_vld(vld3),
`ifdef OR_GATE_DEMUX_HITCNT_EN
    .hit_cnt(hc3),
`endif
    .sel_err(err3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cap(input logic e, input logic va, input logic vb, input logic [1:0] s);
    @(negedge clk);
    en = e; a = va; b = vb; sel = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("rst_dm4", 32'(dm4), 0);
    check("rst_vld4", 32'(vld4), 0);
    check("rst_err4", 32'(err4), 0);
    @(negedge clk);
    rst = 1'b0;
    // combinational truth table, en=0
    begin
      logic [1:0] ab [7] = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00};
      logic       ex [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 7; i++) begin
        {a, b} = ab[i];
        #1;
        check("or4", 32'(or4), 32'(ex[i]));
        check("or3", 32'(or3), 32'(ex[i]));
        #9;
      end
    end
    check("tt_dm4", 32'(dm4), 0);
    check("tt_vld4", 32'(vld4), 0);
    // lane steering, back-to-back captures
    for (int i = 0; i < 4; i++) begin
      cap(1'b1, 1'b1, 1'b0, 2'(i));
      check("steer_vld", 32'(vld4), 32'(1) << i);
      check("steer_dm", 32'(dm4), 32'(1) << i);
      check("steer_err", 32'(err4), 0);
    end
    cap(1'b1, 1'b0, 1'b1, 2'd2);
    check("pre_hold_dm", 32'(dm4), 32'h4);
    for (int i = 0; i < 5; i++) begin
      cap(1'b0, 1'b1, 1'b1, 2'd0);
      check("hold_dm", 32'(dm4), 32'h4);
      check("hold_vld", 32'(vld4), 0);
    end
    cap(1'b1, 1'b0, 1'b0, 2'd1);
    check("zero_vld", 32'(vld4), 32'h2);
    check("zero_dm", 32'(dm4), 0);
    // out-of-range on the NUM_OUT=3 instance
    cap(1'b1, 1'b1, 1'b0, 2'd1);
    check("n3_dm", 32'(dm3), 32'h2);
    check("n3_vld", 32'(vld3), 32'h2);
    cap(1'b1, 1'b1, 1'b0, 2'd3);
    check("oor_vld", 32'(vld3), 0);
    check("oor_err", 32'(err3), 1);
    check("oor_dm", 32'(dm3), 32'h2);
    check("oor_n4_vld", 32'(vld4), 32'h8);
    cap(1'b0, 1'b0, 1'b0, 2'd3);
    check("err_hold", 32'(err3), 1);
    cap(1'b1, 1'b1, 1'b0, 2'd0);
    check("err_clr", 32'(err3), 0);
    check("err_clr_dm", 32'(dm3), 32'h1);
    // async reset mid-operation, checked before the next clock edge
    cap(1'b1, 1'b1, 1'b0, 2'd2);
    check("pre_rst_vld", 32'(vld4), 32'h4);
    check("pre_rst_dm", 32'(dm4), 32'h4);
    #1 rst = 1'b1;
    #1;
    check("arst_dm4", 32'(dm4), 0);
    check("arst_vld4", 32'(vld4), 0);
    check("arst_dm3", 32'(dm3), 0);
    check("arst_vld3", 32'(vld3), 0);
    @(posedge clk);
    #1;
    check("rst_held_dm4", 32'(dm4), 0);
    check("rst_held_vld4", 32'(vld4), 0);
    @(negedge clk);
    rst = 1'b0;
`ifdef OR_GATE_DEMUX_HITCNT_EN
    check("hc_rst", 32'(hc3), 0);
    cap(1'b1, 1'b1, 1'b0, 2'd0);
    cap(1'b1, 1'b0, 1'b1, 2'd1);
    cap(1'b1, 1'b0, 1'b0, 2'd2);
    cap(1'b1, 1'b1, 1'b1, 2'd3);
    cap(1'b1, 1'b1, 1'b0, 2'd2);
    cap(1'b0, 1'b1, 1'b0, 2'd0);
    check("hc3_count", 32'(hc3), 3);
    check("hc4_count", 32'(hc4), 4);
    @(negedge clk);
    en = 1'b1; a = 1'b1; b = 1'b0; sel = 2'd0;
    repeat (65540) @(posedge clk);
    #1;
    check("hc_sat", 32'(hc3), 32'hFFFF);
    @(posedge clk);
    #1;
    check("hc_sat_hold", 32'(hc3), 32'hFFFF);
    @(negedge clk);
    en = 1'b0;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
